// File: rtl/alu_shift_pkg.sv
// Shared definitions for the ALU shift/rotate operators.
// State encoding, default widths and shift-kind encodings.
package alu_shift_pkg;

  localparam int WIDTH = 16;
  localparam int CNT_W = 4;

  localparam logic SHIFT_LOGICAL = 1'b0;
  localparam logic SHIFT_ARITH   = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } shift_state_e;

endpackage

// File: rtl/alu_lsr_iter.sv
// Iterative one-bit-per-cycle right shifter (logical/arithmetic)
// with a start/busy/done handshake for the multi-cycle datapath.
module alu_lsr_iter
  import alu_shift_pkg::*;
#(
  parameter int WIDTH = alu_shift_pkg::WIDTH,
  parameter int CNT_W = alu_shift_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             arith,
  input  logic [WIDTH-1:0] operand1,
  input  logic [CNT_W-1:0] immediate_offset,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dout,
  output logic             carry_out
);

  shift_state_e     state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fill_q, fill_d;
  logic             carry_q, carry_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    fill_d  = fill_q;
    carry_d = carry_q;
    unique case (state_q)
      SHIFT: begin
        carry_d = data_q[0];
        data_d  = {fill_q, data_q[WIDTH-1:1]};
        cnt_d   = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1))
          state_d = DONE;
      end
      default: begin
        state_d = IDLE;
        if (start) begin
          data_d  = operand1;
          cnt_d   = immediate_offset;
          fill_d  = operand1[WIDTH-1] & (arith == SHIFT_ARITH);
          carry_d = 1'b0;
          state_d = (immediate_offset == '0) ? DONE : SHIFT;
        end
      end
    endcase
    busy_d = (state_d == SHIFT);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      fill_q  <= 1'b0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      fill_q  <= fill_d;
      carry_q <= carry_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign dout      = data_q;
  assign carry_out = carry_q;

endmodule

// File: tb/tb_alu_lsr_iter.sv
// Scoreboard bench for alu_lsr_iter.
// Expectations are queued at start and checked at done.
module tb_alu_lsr_iter;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        arith;
  logic [15:0] operand1;
  logic [3:0]  immediate_offset;
  logic        busy;
  logic        done;
  logic [15:0] dout;
  logic        carry_out;

  typedef struct {
    logic [15:0] dout;
    logic        carry;
    int          lat;
    int          busy_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  alu_lsr_iter dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .arith            (arith),
    .operand1         (operand1),
    .immediate_offset (immediate_offset),
    .busy             (busy),
    .done             (done),
    .dout             (dout),
    .carry_out        (carry_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [16:0] model(input logic [15:0] op,
                                        input int n,
                                        input logic ar);
    logic [15:0] v;
    logic        c;
    v = op;
    c = 1'b0;
    for (int i = 0; i < n; i++) begin
      c = v[0];
      v = {op[15] & ar, v[15:1]};
    end
    return {c, v};
  endfunction

  task automatic send(input logic [15:0] op,
                      input int n,
                      input logic ar);
    exp_t e;
    logic [16:0] r;
    r = model(op, n, ar);
    e.dout     = r[15:0];
    e.carry    = r[16];
    e.lat      = n + 1;
    e.busy_cyc = n;
    exp_q.push_back(e);
    start            = 1'b1;
    operand1         = op;
    immediate_offset = 4'(n);
    arith            = ar;
  endtask

  // inject > 0 pulses an ignored start at that edge count
  task automatic wait_done(input string tag, input int inject);
    int   edges;
    int   bcnt;
    bit   seen;
    exp_t e;
    edges = 0;
    bcnt  = 0;
    seen  = 0;
    while (!seen && edges < 40) begin
      @(posedge clk);
      #1;
      edges++;
      if (edges == 1) start = 1'b0;
      if (inject > 0 && edges == inject) begin
        start            = 1'b1;
        operand1         = 16'h0001;
        immediate_offset = 4'd1;
        arith            = 1'b0;
      end
      if (inject > 0 && edges == inject + 1) start = 1'b0;
      if (busy) bcnt++;
      if (done) seen = 1;
    end
    e = exp_q.pop_front();
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_latency"}, 32'(edges), 32'(e.lat));
    check({tag, "_busy_cycles"}, 32'(bcnt), 32'(e.busy_cyc));
    check({tag, "_dout"}, 32'(dout), 32'(e.dout));
    check({tag, "_carry"}, 32'(carry_out), 32'(e.carry));
  endtask

  initial begin
    rst_n            = 1'b0;
    start            = 1'b0;
    arith            = 1'b0;
    operand1         = '0;
    immediate_offset = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_carry", 32'(carry_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    send(16'hB3C5, 4, 1'b0);
    wait_done("lsr4", 0);
    @(posedge clk);
    #1;
    check("lsr4_done_one_cycle", 32'(done), 32'd0);
    check("lsr4_dout_held", 32'(dout), 32'h0B3C);

    send(16'h8001, 15, 1'b1);
    wait_done("asr15", 0);

    @(posedge clk);
    #1;
    send(16'h1234, 0, 1'b0);
    wait_done("zero", 0);

    @(posedge clk);
    #1;
    send(16'hFFFF, 8, 1'b0);
    wait_done("busy_start", 3);

    @(posedge clk);
    #1;
    send(16'hA5A5, 3, 1'b1);
    wait_done("b2b_first", 0);
    send(16'h00F0, 4, 1'b0);
    wait_done("b2b_second", 0);

    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      send(16'($urandom), int'($urandom_range(0, 15)), 1'($urandom));
      wait_done("rand", 0);
    end

    @(posedge clk);
    #1;
    start            = 1'b1;
    operand1         = 16'hFFFF;
    immediate_offset = 4'd10;
    arith            = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid_busy_before_rst", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_dout", 32'(dout), 32'd0);
    check("mid_rst_carry", 32'(carry_out), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("mid_rst_no_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("after_rst_idle_done", 32'(done), 32'd0);
    check("after_rst_idle_busy", 32'(busy), 32'd0);

    send(16'h4000, 14, 1'b0);
    wait_done("post_rst", 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
